bit_serial_addsub_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 1-bit full add/sub slice, LSB first, one bit per clock. It latches operands on a start request, runs the slice WIDTH times while carrying the carry/borrow in a flop, then presents the assembled result with a one-cycle done pulse. It sits between a requesting control unit and the 1-bit add/sub datapath as its only driver.

---
 rtl/bit_serial_addsub_ctrl.sv | 76 +++++++
 tb/tb_bit_serial_addsub_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub_ctrl.sv
// bit_serial_addsub_ctrl: LSB-first bit-serial add/sub sequencer over one 1-bit slice; optional signed overflow via ADDSUB_OVF_EN
module bit_serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             op_r, cy, bx, s, co, last;
  logic [CW-1:0]    cnt;
  // one full add/sub slice; b is inverted for subtract and cy starts at op
  always_comb begin
    bx   = b_sr[0] ^ op_r;
    s    = a_sr[0] ^ bx ^ cy;
    co   = (a_sr[0] & bx) | (cy & (a_sr[0] ^ bx));
    last = cnt == CW'(WIDTH - 1);
  end
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign carry_out = cy;
`ifdef ADDSUB_OVF_EN
  logic ovf;
  assign overflow = ovf;
  // signed overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= cy ^ co;
  end
`else
  assign overflow = 1'b0;
`endif
  // sequencer: latch on start, shift one bit per cycle, then a single DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      op_r   <= 1'b0;
      cy     <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        a_sr  <= a;
        b_sr  <= b;
        op_r  <= op;
        cy    <= op;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      result <= {s, result[WIDTH-1:1]};
      cy     <= co;
      cnt    <= cnt + 1'b1;
      state  <= last ? DONE : RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// tb_bit_serial_addsub_ctrl: scoreboard bench for the bit-serial add/sub sequencer
module tb_bit_serial_addsub_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, carry_out, overflow;
  logic [7:0] result;
  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
`ifdef ADDSUB_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  bit_serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("sb_res_co_ovf", {result, carry_out, overflow}, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ec, input logic eo);
    exp_q.push_back({er, ec, eo & OVF});
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_e0", busy, 1);
    repeat (7) @(posedge clk);
    #1 chk("busy_e7", busy, 1);
    chk("done_early", done, 0);
    @(posedge clk);
    #1 chk("busy_e8", busy, 0);
    chk("done_e8", done, 1);
    @(posedge clk);
    #1 chk("done_len", done, 0);
    chk("held_res", result, er);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_co", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 8'h25, 8'h1A, 8'h3F, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0);
    run_op(1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    // start and operand churn while busy, start during DONE
    exp_q.push_back({8'h33, 1'b0, 1'b0});
    op = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'hFF; b = 8'hFF; op = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 4; i < 8; i++) begin
      @(posedge clk); #1 a = ~a; b = 8'($urandom);
    end
    @(posedge clk);
    #1 chk("ign_done", done, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ign_done_start", busy, 0);
    repeat (12) @(posedge clk);
    #1 chk("ign_idle", busy, 0);
    chk("ign_res", result, 8'h33);
    // reset abort on the 4th RUN edge
    op = 1'b0; a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 0);
    chk("abort_co", carry_out, 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("abort_idle", busy, 0);
    run_op(1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);
    // start held high: one op every 10 cycles
    repeat (3) exp_q.push_back({8'h20, 1'b1, 1'b0});
    op = 1'b1; a = 8'h30; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 30; c++) begin
      @(posedge clk);
      #1 chk("b2b_done", done, (c % 10) == 8);
      if (c == 29) start = 1'b0;
    end
    repeat (12) @(posedge clk);
    #1 chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
